// File: rtl/mu0_pkg.sv
// Shared opcode values, phase encoding and decoded-opcode strobe bundle for the MU0 control unit.
package mu0_pkg;

  localparam int unsigned OpLda = 0;
  localparam int unsigned OpSta = 1;
  localparam int unsigned OpAdd = 2;
  localparam int unsigned OpSub = 3;
  localparam int unsigned OpJmp = 4;
  localparam int unsigned OpJmi = 5;
  localparam int unsigned OpJeq = 6;
  localparam int unsigned OpStp = 7;
  localparam int unsigned OpLdi = 8;
  localparam int unsigned OpLsl = 9;
  localparam int unsigned OpLsr = 10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // One-hot opcode strobes; ill covers every undefined code.
  typedef struct packed {
    logic lda;
    logic sta;
    logic add;
    logic sub;
    logic jmp;
    logic jmi;
    logic jeq;
    logic stp;
    logic ldi;
    logic lsl;
    logic lsr;
    logic ill;
  } op_dec_t;

endpackage

// File: rtl/mu0_op_decode.sv
// Combinational opcode decoder: instruction-register opcode field to one-hot strobes.
module mu0_op_decode
  import mu0_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0] op_i,
  output op_dec_t         dec_o
);

  // Exactly one strobe is raised for any opcode value.
  always_comb begin
    dec_o = '0;
    unique case (op_i)
      OP_W'(OpLda): dec_o.lda = 1'b1;
      OP_W'(OpSta): dec_o.sta = 1'b1;
      OP_W'(OpAdd): dec_o.add = 1'b1;
      OP_W'(OpSub): dec_o.sub = 1'b1;
      OP_W'(OpJmp): dec_o.jmp = 1'b1;
      OP_W'(OpJmi): dec_o.jmi = 1'b1;
      OP_W'(OpJeq): dec_o.jeq = 1'b1;
      OP_W'(OpStp): dec_o.stp = 1'b1;
      OP_W'(OpLdi): dec_o.ldi = 1'b1;
      OP_W'(OpLsl): dec_o.lsl = 1'b1;
      OP_W'(OpLsr): dec_o.lsr = 1'b1;
      default:      dec_o.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_control_unit.sv
// MU0 control unit: phase sequencer with memory wait states, halt, illegal-opcode flag,
// retire counter and the datapath control equations.
module mu0_control_unit
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [OP_W-1:0]   OP,
  input  logic [DATA_W-1:0] ACC_OUT,
  input  logic              MEM_READY,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              HALTED,
  output logic              IR_LOAD,
  output logic              EXTRA,
  output logic              MUX1,
  output logic              MUX3,
  output logic              MUX4,
  output logic              SLOAD,
  output logic              CNT_EN,
  output logic              WREN,
  output logic              SLOAD_ACC,
  output logic              ENABLE_ACC,
  output logic              SHIFT,
  output logic              ADD_SUB,
  output logic              ILLEGAL,
  output logic [CNT_W-1:0]  INSTR_CNT
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  op_dec_t dec;
  logic    flag_z, flag_n;
  logic    in_e1, in_e2;
  logic    mem_rd;
  logic    ir_load;
  logic    retire;

  mu0_op_decode #(
    .OP_W(OP_W)
  ) u_op_decode (
    .op_i (OP),
    .dec_o(dec)
  );

  assign flag_z = (ACC_OUT == '0);
  assign flag_n = ACC_OUT[DATA_W-1];
  assign in_e1  = (state_q == S_EXEC1);
  assign in_e2  = (state_q == S_EXEC2);
  // Opcodes that read memory in EXEC1 and write the accumulator in EXEC2.
  assign mem_rd = dec.lda | dec.add | dec.sub;

  assign FETCH     = (state_q == S_FETCH);
  assign EXEC1     = in_e1;
  assign EXEC2     = in_e2;
  assign HALTED    = (state_q == S_HALT);
  assign ILLEGAL   = illegal_q;
  assign INSTR_CNT = instr_cnt_q;

  // Next phase; memory phases hold until MEM_READY.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (MEM_READY) begin
          ir_load = 1'b1;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (mem_rd) begin
          if (MEM_READY) state_d = S_EXEC2;
        end else if (dec.sta) begin
          if (MEM_READY) state_d = S_FETCH;
        end else if (dec.stp) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC2: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Retire on the cycle the instruction leaves its last exec phase; STP and ILL count too.
  always_comb begin
    retire      = in_e2 | (in_e1 & (state_d != S_EXEC1) & (state_d != S_EXEC2));
    illegal_d   = illegal_q | (in_e1 & dec.ill);
    instr_cnt_d = instr_cnt_q;
    if (retire) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  // Datapath controls; state-changing strobes are suppressed while RESET is high.
  always_comb begin
    EXTRA      = in_e1 & mem_rd;
    MUX1       = (in_e1 & (dec.lda | dec.sta | dec.add | dec.sub | dec.jmp |
                           (dec.jmi & flag_n) | (dec.jeq & flag_z))) |
                 (in_e2 & mem_rd);
    MUX3       = ((in_e1 | in_e2) & (dec.lda | dec.ldi)) | (in_e1 & (dec.add | dec.sub));
    MUX4       = in_e1 & dec.lsr;
    SHIFT      = in_e1 & (dec.lsl | dec.lsr);
    ADD_SUB    = dec.add & (in_e1 | in_e2);
    IR_LOAD    = ~RESET & ir_load;
    SLOAD      = ~RESET & in_e1 & (dec.jmp | (dec.jmi & flag_n) | (dec.jeq & flag_z));
    CNT_EN     = ~RESET & ((in_e2 & mem_rd) |
                           (in_e1 & (dec.ldi | dec.lsl | dec.lsr | (dec.sta & MEM_READY) |
                                     (dec.jmi & ~flag_n) | (dec.jeq & ~flag_z) | dec.ill)));
    WREN       = ~RESET & in_e1 & dec.sta;
    SLOAD_ACC  = ~RESET & ((in_e1 & dec.ldi) | (in_e2 & mem_rd));
    ENABLE_ACC = ~RESET & ((in_e1 & (dec.ldi | dec.lsl | dec.lsr)) | (in_e2 & mem_rd));
  end

  // State, sticky illegal flag and retire counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_FETCH;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule

// File: tb/tb_mu0_control_unit.sv
// Self-checking bench for mu0_control_unit: a 16-bit/16-bit-counter instance and an
// 8-bit/2-bit-counter instance share clock, reset, opcode and MEM_READY.
module tb_mu0_control_unit;

  localparam int LDA = 0, STA = 1, ADD = 2, SUB = 3, JMP = 4, JMI = 5, JEQ = 6, STP = 7;
  localparam int LDI = 8, LSL = 9, LSR = 10;
  localparam int PF = 0, P1 = 1, P2 = 2, PH = 3;

  // Control vector order: IR_LOAD EXTRA MUX1 MUX3 MUX4 SLOAD CNT_EN WREN SLOAD_ACC ENABLE_ACC
  // SHIFT ADD_SUB
  localparam logic [11:0] K_IR = 12'h800, K_EXTRA = 12'h400, K_MUX1 = 12'h200;
  localparam logic [11:0] K_MUX3 = 12'h100, K_MUX4 = 12'h080, K_SLOAD = 12'h040;
  localparam logic [11:0] K_CNT = 12'h020, K_WREN = 12'h010, K_SLD = 12'h008;
  localparam logic [11:0] K_ENA = 12'h004, K_SHIFT = 12'h002, K_ADDSUB = 12'h001;
  localparam logic [11:0] K_FORCED = K_IR | K_SLOAD | K_CNT | K_WREN | K_SLD | K_ENA;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [3:0]  op;
  logic [15:0] acc16;
  logic [7:0]  acc8;

  wire [3:0]  ph16, ph8;
  wire [11:0] c16, c8;
  wire        ill16, ill8;
  wire [15:0] cnt16;
  wire [1:0]  cnt8;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  bit model_ill = 1'b0;

  always #5 clk = ~clk;

  mu0_control_unit #(.DATA_W(16), .OP_W(4), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .OP(op), .ACC_OUT(acc16), .MEM_READY(mem_ready),
    .FETCH(ph16[3]), .EXEC1(ph16[2]), .EXEC2(ph16[1]), .HALTED(ph16[0]),
    .IR_LOAD(c16[11]), .EXTRA(c16[10]), .MUX1(c16[9]), .MUX3(c16[8]), .MUX4(c16[7]),
    .SLOAD(c16[6]), .CNT_EN(c16[5]), .WREN(c16[4]), .SLOAD_ACC(c16[3]),
    .ENABLE_ACC(c16[2]), .SHIFT(c16[1]), .ADD_SUB(c16[0]),
    .ILLEGAL(ill16), .INSTR_CNT(cnt16)
  );

  mu0_control_unit #(.DATA_W(8), .OP_W(4), .CNT_W(2)) dut8 (
    .CLK(clk), .RESET(rst), .OP(op), .ACC_OUT(acc8), .MEM_READY(mem_ready),
    .FETCH(ph8[3]), .EXEC1(ph8[2]), .EXEC2(ph8[1]), .HALTED(ph8[0]),
    .IR_LOAD(c8[11]), .EXTRA(c8[10]), .MUX1(c8[9]), .MUX3(c8[8]), .MUX4(c8[7]),
    .SLOAD(c8[6]), .CNT_EN(c8[5]), .WREN(c8[4]), .SLOAD_ACC(c8[3]),
    .ENABLE_ACC(c8[2]), .SHIFT(c8[1]), .ADD_SUB(c8[0]),
    .ILLEGAL(ill8), .INSTR_CNT(cnt8)
  );

  // What each instruction does in each phase, written per opcode.
  function automatic logic [11:0] exp_ctrl(int ph, int opc, logic z, logic n, logic r);
    logic [11:0] e;
    e = 12'h000;
    if (ph == PF) return r ? K_IR : 12'h000;
    if (ph != P1 && ph != P2) return 12'h000;
    case (opc)
      LDA: e = (ph == P1) ? (K_EXTRA | K_MUX1 | K_MUX3)
                          : (K_MUX1 | K_MUX3 | K_CNT | K_SLD | K_ENA);
      ADD: e = (ph == P1) ? (K_EXTRA | K_MUX1 | K_MUX3 | K_ADDSUB)
                          : (K_MUX1 | K_CNT | K_SLD | K_ENA | K_ADDSUB);
      SUB: e = (ph == P1) ? (K_EXTRA | K_MUX1 | K_MUX3)
                          : (K_MUX1 | K_CNT | K_SLD | K_ENA);
      STA: e = K_MUX1 | K_WREN | (r ? K_CNT : 12'h000);
      JMP: e = K_MUX1 | K_SLOAD;
      JMI: e = n ? (K_MUX1 | K_SLOAD) : K_CNT;
      JEQ: e = z ? (K_MUX1 | K_SLOAD) : K_CNT;
      STP: e = 12'h000;
      LDI: e = K_MUX3 | K_CNT | K_SLD | K_ENA;
      LSL: e = K_CNT | K_ENA | K_SHIFT;
      LSR: e = K_CNT | K_ENA | K_SHIFT | K_MUX4;
      default: e = K_CNT;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    op = 4'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    model_ill = 1'b0;
  endtask

  // Walk one instruction cycle by cycle from FETCH, checking both instances every cycle.
  task automatic run_instr(input int opc, input logic [15:0] a16, input logic [7:0] a8,
                           input int fw, input int ew);
    int phs[$];
    bit rds[$];
    logic [11:0] e16, e8;
    logic [3:0] oh;
    for (int i = 0; i < fw; i++) begin phs.push_back(PF); rds.push_back(1'b0); end
    phs.push_back(PF); rds.push_back(1'b1);
    if (opc == LDA || opc == ADD || opc == SUB) begin
      for (int i = 0; i < ew; i++) begin phs.push_back(P1); rds.push_back(1'b0); end
      phs.push_back(P1); rds.push_back(1'b1);
      phs.push_back(P2); rds.push_back(1'($urandom));
    end else if (opc == STA) begin
      for (int i = 0; i < ew; i++) begin phs.push_back(P1); rds.push_back(1'b0); end
      phs.push_back(P1); rds.push_back(1'b1);
    end else begin
      phs.push_back(P1); rds.push_back(1'($urandom));
    end
    for (int c = 0; c < phs.size(); c++) begin
      mem_ready = rds[c];
      if (phs[c] == PF) begin
        op = 4'($urandom); acc16 = 16'($urandom); acc8 = 8'($urandom);
      end else begin
        op = 4'(opc); acc16 = a16; acc8 = a8;
      end
      oh  = 4'b1000 >> phs[c];
      e16 = exp_ctrl(phs[c], opc, a16 == 16'h0, a16[15], rds[c]);
      e8  = exp_ctrl(phs[c], opc, a8 == 8'h0, a8[7], rds[c]);
      @(negedge clk);
      n_checks++;
      if ({ph16, c16} !== {oh, e16}) begin
        n_errors++;
        $display("FAIL ctrl16 op=%0d cyc=%0d: got ph=%b ctrl=%b, expected ph=%b ctrl=%b",
                 opc, c, ph16, c16, oh, e16);
      end
      n_checks++;
      if ({ph8, c8} !== {oh, e8}) begin
        n_errors++;
        $display("FAIL ctrl8 op=%0d cyc=%0d: got ph=%b ctrl=%b, expected ph=%b ctrl=%b",
                 opc, c, ph8, c8, oh, e8);
      end
      n_checks++;
      if ({ill16, ill8} !== {model_ill, model_ill}) begin
        n_errors++;
        $display("FAIL illegal op=%0d cyc=%0d: got %b%b, expected %b", opc, c, ill16, ill8,
                 model_ill);
      end
      n_checks++;
      if (cnt16 !== 16'(model_cnt) || cnt8 !== 2'(model_cnt)) begin
        n_errors++;
        $display("FAIL instr_cnt op=%0d cyc=%0d: got %0d/%0d, expected %0d/%0d", opc, c,
                 cnt16, cnt8, 16'(model_cnt), 2'(model_cnt));
      end
      @(posedge clk); #1;
      if (phs[c] == P1 && opc > LSR) model_ill = 1'b1;
    end
    model_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = 4'(LDA); acc16 = 16'h0; acc8 = 8'h0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ph16, c16} !== {4'b1000, 12'h000} || {ph8, c8} !== {4'b1000, 12'h000}) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b %b / %b %b, expected 1000 000000000000", ph16, c16,
               ph8, c8);
    end
    n_checks++;
    if ({ill16, ill8, cnt16, cnt8} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_regs: got ill=%b%b cnt=%0d/%0d, expected 0", ill16, ill8, cnt16,
               cnt8);
    end
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 0; model_ill = 1'b0;
  endtask

  task automatic test_lda();
    run_instr(LDA, 16'h1234, 8'h12, 0, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt16 !== 16'd1 || ph16 !== 4'b1000) begin
      n_errors++;
      $display("FAIL lda_retire: got cnt=%0d ph=%b, expected cnt=1 ph=1000", cnt16, ph16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sta_wait();
    run_instr(STA, 16'($urandom), 8'($urandom), 1, 3);
    run_instr(STA, 16'($urandom), 8'($urandom), 0, 0);
  endtask

  task automatic test_jumps();
    run_instr(JEQ, 16'h0000, 8'h00, 0, 0);
    run_instr(JEQ, 16'h0001, 8'h01, 0, 0);
    run_instr(JMI, 16'h8000, 8'h80, 0, 0);
    run_instr(JMI, 16'h7fff, 8'h7f, 1, 0);
    run_instr(JMP, 16'h0000, 8'h55, 0, 0);
  endtask

  task automatic test_illegal_halt();
    do_reset();
    run_instr(12, 16'($urandom), 8'($urandom), 0, 0);
    run_instr(STP, 16'($urandom), 8'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom); op = 4'($urandom);
      acc16 = 16'($urandom); acc8 = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if ({ph16, c16} !== {4'b0001, 12'h000} || {ph8, c8} !== {4'b0001, 12'h000}) begin
        n_errors++;
        $display("FAIL halt_ctrl cyc=%0d: got %b %b / %b %b, expected 0001 000000000000", i,
                 ph16, c16, ph8, c8);
      end
      n_checks++;
      if (cnt16 !== 16'd2 || cnt8 !== 2'd2 || ill16 !== 1'b1 || ill8 !== 1'b1) begin
        n_errors++;
        $display("FAIL halt_regs cyc=%0d: got cnt=%0d/%0d ill=%b%b, expected 2/2 11", i,
                 cnt16, cnt8, ill16, ill8);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_instr(13, 16'($urandom), 8'($urandom), 0, 0);
    mem_ready = 1'b1; op = 4'(STA);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (c16[4] !== 1'b1 || ph16 !== 4'b0100) begin
      n_errors++;
      $display("FAIL sta_wait_wren: got wren=%b ph=%b, expected 1 0100", c16[4], ph16);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ((c16 & K_FORCED) !== 12'h000 || (c8 & K_FORCED) !== 12'h000 || ph16 !== 4'b0100) begin
      n_errors++;
      $display("FAIL reset_forced: got ctrl=%b/%b ph=%b, expected forced bits 0 ph=0100",
               c16, c8, ph16);
    end
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 0; model_ill = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ph16 !== 4'b1000 || ph8 !== 4'b1000 || cnt16 !== 16'd0 || cnt8 !== 2'd0 ||
        ill16 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_after_wait: got ph=%b/%b cnt=%0d/%0d ill=%b, expected 1000 0 0",
               ph16, ph8, cnt16, cnt8, ill16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(LDI + (i % 3), 16'($urandom), 8'($urandom), 0, 0);
    @(negedge clk);
    n_checks++;
    if (cnt8 !== 2'd1 || cnt16 !== 16'd5) begin
      n_errors++;
      $display("FAIL cnt_wrap: got %0d/%0d, expected 5/1", cnt16, cnt8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int opc;
    logic [15:0] a16;
    logic [7:0] a8;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      opc = $urandom_range(0, 15);
      if (opc == STP) opc = LDI;
      case ($urandom_range(0, 3))
        0: begin a16 = 16'h0; a8 = 8'h0; end
        1: begin a16 = 16'($urandom) | 16'h8000; a8 = 8'($urandom) | 8'h80; end
        default: begin a16 = 16'($urandom); a8 = 8'($urandom); end
      endcase
      run_instr(opc, a16, a8, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_instr(STP, 16'($urandom), 8'($urandom), 1, 0);
    mem_ready = 1'($urandom);
    @(negedge clk);
    n_checks++;
    if (ph16 !== 4'b0001 || cnt16 !== 16'(model_cnt) || cnt8 !== 2'(model_cnt)) begin
      n_errors++;
      $display("FAIL random_halt: got ph=%b cnt=%0d/%0d, expected 0001 %0d/%0d", ph16, cnt16,
               cnt8, 16'(model_cnt), 2'(model_cnt));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; op = 4'h0; acc16 = 16'h0; acc8 = 8'h0;
    test_reset();
    test_lda();
    test_sta_wait();
    test_jumps();
    test_illegal_halt();
    test_reset_mid_wait();
    test_cnt_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/mu0_control_unit.md
# mu0_control_unit

Parametrised MU0 control unit combining the instruction decoder with its own phase sequencer (FETCH/EXEC1/EXEC2/HALT). It sits between the instruction register, the accumulator and the PC/memory datapath. It replaces externally driven phase strobes with an internal state machine that adds:
- memory wait states,
- a halting STP,
- illegal-opcode detection,
- an instruction retire counter.

## Interface
Parameters:
- DATA_W, 16, accumulator width; drives zero/negative flag derivation.
- OP_W, 4, opcode field width (≥4). Codes above 0xA are illegal.
- CNT_W, 16, retire counter width.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high.
- OP  in  OP_W  opcode field of the instruction register.
- ACC_OUT  in  DATA_W  accumulator value.
- MEM_READY  in  1  memory completes the current access this cycle.
- FETCH, EXEC1, EXEC2, HALTED  out  1  one-hot phase status.
- IR_LOAD  out  1  load instruction register.
- EXTRA, MUX1, MUX3, MUX4, SLOAD, CNT_EN, WREN, SLOAD_ACC, ENABLE_ACC, SHIFT, ADD_SUB  out  1  datapath controls.
- ILLEGAL  out  1  sticky flag: an undefined opcode was executed.
- INSTR_CNT  out  CNT_W  retired-instruction count.

## Operation
Opcodes:
- LDA 0, STA 1, ADD 2, SUB 3
- JMP 4, JMI 5, JEQ 6, STP 7
- LDI 8, LSL 9, LSR A
- ILL: any other value

Flags (combinational):
- Z = (ACC_OUT == 0)
- N = ACC_OUT[DATA_W-1]

State transitions:
- FETCH: stay while !MEM_READY. When MEM_READY, assert IR_LOAD and go to EXEC1.
- EXEC1 for LDA/ADD/SUB: stay while !MEM_READY, else go to EXEC2.
- EXEC1 for STA: stay while !MEM_READY, else go to FETCH.
- EXEC1 for STP: go to HALT.
- EXEC1 for all other opcodes: go to FETCH with no wait.
- EXEC2: go to FETCH.
- HALT: stays in HALT until RESET.

Controls (r = MEM_READY):
- MUX1 = EXEC1&(LDA|STA|ADD|SUB|JMP|JMI&N|JEQ&Z) | EXEC2&(LDA|ADD|SUB)
- EXTRA = EXEC1&(LDA|ADD|SUB)
- MUX3 = (EXEC1|EXEC2)&(LDA|LDI) | EXEC1&(ADD|SUB)
- SLOAD = EXEC1&(JMP|JMI&N|JEQ&Z)
- CNT_EN = EXEC2&(LDA|ADD|SUB) | EXEC1&(LDI|LSL|LSR|STA&r|JMI&~N|JEQ&~Z|ILL)
- WREN = EXEC1&STA; held for the whole wait.
- SLOAD_ACC = EXEC1&LDI | EXEC2&(LDA|ADD|SUB)
- ENABLE_ACC = EXEC1&(LDI|LSL|LSR) | EXEC2&(LDA|ADD|SUB)
- SHIFT = EXEC1&(LSL|LSR); MUX4 = EXEC1&LSR; ADD_SUB = ADD & (EXEC1|EXEC2)
- All controls are 0 in FETCH (except IR_LOAD) and in HALT.

Counters and flags:
- ILLEGAL sets on the EXEC1 cycle of an ILL opcode. It clears only on RESET.
- INSTR_CNT increments once per instruction, on the cycle leaving the final exec state. It counts STP and ILL and wraps modulo 2^CNT_W.

## Timing
- Reset values: phase is FETCH, so FETCH=1 and EXEC1=EXEC2=HALTED=0. ILLEGAL=0, INSTR_CNT=0.
- While RESET is high, IR_LOAD, CNT_EN, SLOAD, WREN, SLOAD_ACC and ENABLE_ACC are forced 0. This applies even mid-instruction or mid-wait.
- Outputs are combinational from the registered state, OP, flags and MEM_READY. There is no output register, so a control is valid in the same cycle as its phase.
- Minimum cycles per instruction with MEM_READY=1:
  - LDA/ADD/SUB: 3
  - all others: 2
- Each MEM_READY-low cycle adds one cycle in FETCH, or in EXEC1 of LDA/ADD/SUB/STA.
- MEM_READY is ignored in EXEC2, in HALT, and in EXEC1 of non-memory opcodes.
- A jump's N/Z is sampled in its EXEC1 cycle only.
- INSTR_CNT wrap: all-ones + 1 gives 0, with no other side effect.

## Structure
- Package mu0_pkg holds:
  - opcode localparams (LDA..LSR)
  - the state enum (S_FETCH, S_EXEC1, S_EXEC2, S_HALT)
- Sub-module mu0_op_decode: combinational OP to one-hot opcode strobes plus ILL, parametrised by OP_W.
- The top level holds the state register, the ILLEGAL and INSTR_CNT registers, and the control equations.

## Test plan
- Reset, then run LDA (OP=0) with MEM_READY=1 → FETCH, EXEC1, EXEC2, FETCH. EXTRA=1 in EXEC1; SLOAD_ACC=ENABLE_ACC=CNT_EN=1 in EXEC2; INSTR_CNT=1.
- STA with MEM_READY low for 3 cycles in EXEC1 → WREN=1 for 4 cycles, CNT_EN=1 only on the final cycle, then FETCH.
- JEQ with ACC_OUT=0 → SLOAD=1, CNT_EN=0. Repeat with ACC_OUT=0x0001 → SLOAD=0, CNT_EN=1.
- JMI with ACC_OUT=0x8000 (DATA_W=16) → SLOAD=1. Repeat with DATA_W=8 and ACC_OUT=0x80 → SLOAD=1.
- OP=0xC → CNT_EN=1 in EXEC1 and ILLEGAL rises and stays 1. Then STP → HALTED=1, all controls 0 for 10 cycles, and INSTR_CNT=2 from reset.
- RESET asserted during an EXEC1 wait → WREN=0 in the reset cycle, FETCH=1 next cycle, INSTR_CNT=0. With CNT_W=2, 5 NOP-class instructions → INSTR_CNT=1.
